saturate_shift_pipe: RTL and testbench
======================================

Name: saturate_shift_pipe

Overview:
Parametrised successor to the fixed 32->16 saturating narrower. It performs an arithmetic right shift with a runtime shift amount, optionally rounds, then saturates to OUT_W bits. Two pipeline stages with valid/ready handshaking; reports per-sample high/low clip flags and keeps a saturating clip event counter. Sits between wide accumulators (MAC/filter outputs) and narrow Q-format consumers.

Parameters:
IN_W, 32, signed input width (>= OUT_W+1)
OUT_W, 16, signed output width (>= 2)
SH_W, 5, width of shift port; shift must be <= IN_W-1
CNT_W, 16, width of clip event counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept the input this cycle
in  in  IN_W  signed input sample
shift  in  SH_W  arithmetic right-shift amount, sampled with in on transfer
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
out  out  OUT_W  signed saturated result
sat_hi  out  1  out was clipped to max (qualified by out_valid)
sat_lo  out  1  out was clipped to min (qualified by out_valid)
clear_count  in  1  synchronous clear of sat_count
sat_count  out  CNT_W  number of clipped samples transferred, sticky at max

Behaviour:
- Reset (async, immediate): out_valid=0, out=0, sat_hi=0, sat_lo=0, sat_count=0, internal stage-1 valid=0. in_ready=1 after reset. A sample in flight when reset asserts is discarded.
- Transfer rule: input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready. out, sat_hi and sat_lo stay stable while out_valid&&!out_ready.
- Stage 1 (S1): captures the shifted value. It is an (IN_W+1)-bit sign-extended value, arithmetic-shifted right by shift (floor toward -inf).
- Stage 2 (S2): compares the S1 value against MAX=2^(OUT_W-1)-1 and MIN=-2^(OUT_W-1).
  - value>MAX: out=MAX, sat_hi=1.
  - value<MIN: out=MIN, sat_lo=1.
  - Otherwise: out=low OUT_W bits of value, both flags 0.
  - Equality with MAX or MIN is not a clip.
- Advance rules:
  - S2 loads when S1 valid and (!out_valid||out_ready).
  - S1 loads when in_valid and (!S1valid||S2 loads).
  - in_ready = !S1valid || (!out_valid||out_ready).
  - The ready path is combinational.
- Latency 2 cycles from input transfer to out_valid with out_ready high. Throughput 1 sample/cycle. No bubbles inserted, no sample dropped or reordered under backpressure.
- Counter: increments by 1 on each output transfer with sat_hi||sat_lo. Holds at 2^CNT_W-1, no wrap. clear_count sets it to 0 next edge. If clear and increment coincide, clear wins and the result is 0.
- shift>IN_W-1: result undefined. The bench must not drive it.

Optional Feature:
SATURATE_ROUND_EN
- Defined: S1 adds 2^(shift-1) to the (IN_W+1)-bit extended input before shifting when shift>0 (round half up). The extra bit guarantees no internal overflow, and rounding can push a value into saturation. Latency unchanged.
- Undefined: plain floor shift; no adder is instantiated.

Test Plan:
- shift=0, in=32767 then 32768, out_ready=1 -> two cycles after each: out=0x7FFF sat_hi=0, then out=0x7FFF sat_hi=1; sat_count=1.
- shift=0, in=-32768 then -32769 -> out=0x8000 sat_lo=0, then out=0x8000 sat_lo=1.
- shift=4:
  - Without SATURATE_ROUND_EN: in=524280 -> out=0x7FFF no clip; in=-24 -> out=-2 (0xFFFE).
  - With SATURATE_ROUND_EN: in=524280 -> out=0x7FFF sat_hi=1; in=-24 -> out=-1 (0xFFFF).
- Backpressure: send 4 back-to-back samples 1,2,3,4 (shift=0), out_ready=0 for 3 cycles then 1 -> in_ready drops after 2 accepted; outputs 1,2,3,4 in order, each held stable while stalled.
- Counter: 3 clipped transfers -> sat_count=3. Clipped transfer with clear_count=1 -> sat_count=0. With CNT_W=2, 5 clipped transfers -> sat_count=3.
- Reset mid-stream: assert reset while out_valid=1 and S1 full -> out_valid, out, flags and sat_count go to 0 without a clock edge. After release, the next input appears 2 cycles after its transfer, with no stale sample output.

Source files
------------

// File: rtl/saturate_shift_pipe.sv
// Arithmetic right shift, optional round-half-up (SATURATE_ROUND_EN), saturate to OUT_W; clip flags + sticky clip counter.
// Latency: 2 cycles input transfer to out_valid; 1 sample/cycle throughput.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready; output held while stalled.
module saturate_shift_pipe #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in,
  input  logic [SH_W-1:0]         shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out,
  output logic                    sat_hi,
  output logic                    sat_lo,
  input  logic                    clear_count,
  output logic [CNT_W-1:0]        sat_count
);

  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0]    MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0]    MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [EW-1:0]    ext;
  logic signed [EW-1:0]    shifted;
  logic signed [EW-1:0]    s1_val;
  logic                    s1_vld;
  logic                    s1_load;
  logic                    s2_load;
  logic                    out_xfer;
  logic signed [OUT_W-1:0] sat_val;
  logic                    hi_d;
  logic                    lo_d;

  assign s2_load  = s1_vld && (!out_valid || out_ready);
  assign in_ready = !s1_vld || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef SATURATE_ROUND_EN
  logic signed [EW-1:0] rnd;

  // The extra sign bit keeps in + 2^(shift-1) from overflowing.
  always_comb begin
    ext = {in[IN_W-1], in};
    rnd = '0;
    if (shift != '0) rnd = EW'(1) << (shift - SH_W'(1));
    shifted = (ext + rnd) >>> shift;
  end
`else
  always_comb begin
    ext     = {in[IN_W-1], in};
    shifted = ext >>> shift;
  end
`endif

  always_comb begin
    sat_val = s1_val[OUT_W-1:0];
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    if (s1_val > MAX_V) begin
      sat_val = MAX_O;
      hi_d    = 1'b1;
    end else if (s1_val < MIN_V) begin
      sat_val = MIN_O;
      lo_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_val <= '0;
    end else begin
      if (s1_load) begin
        s1_vld <= 1'b1;
        s1_val <= shifted;
      end else if (s2_load) begin
        s1_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out       <= sat_val;
        sat_hi    <= hi_d;
        sat_lo    <= lo_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear has priority over a coincident clipped transfer; count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (clear_count) begin
      sat_count <= '0;
    end else if (out_xfer && (sat_hi || sat_lo) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_saturate_shift_pipe.sv
// Randomized and directed bench for saturate_shift_pipe against a queue-based reference model.
module tb_saturate_shift_pipe;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SH_W  = 5;
  localparam int CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_dat = '0;
  logic [SH_W-1:0]         shift = '0;
  logic                    out_ready = 1'b0;
  logic                    clear_count = 1'b0;

  logic                    in_ready, out_valid, sat_hi, sat_lo;
  logic signed [OUT_W-1:0] out_dat;
  logic [CNT_W-1:0]        sat_count;
  logic                    in_ready2, out_valid2, sat_hi2, sat_lo2;
  logic signed [OUT_W-1:0] out_dat2;
  logic [1:0]              sat_count2;

  saturate_shift_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in(in_dat),
    .shift(shift), .out_valid(out_valid), .out_ready(out_ready), .out(out_dat),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .clear_count(clear_count), .sat_count(sat_count));

  saturate_shift_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in(in_dat),
    .shift(shift), .out_valid(out_valid2), .out_ready(out_ready), .out(out_dat2),
    .sat_hi(sat_hi2), .sat_lo(sat_lo2), .clear_count(clear_count), .sat_count(sat_count2));

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    bit     hi;
    bit     lo;
    int     t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference: exact integer arithmetic on the spec's rules.
  function automatic exp_t model(longint d, int sh);
    exp_t   r;
    longint v  = d;
    longint mx = (longint'(1) <<< (OUT_W-1)) - 1;
    longint mn = -(mx + 1);
`ifdef SATURATE_ROUND_EN
    if (sh > 0) v = v + (longint'(1) <<< (sh-1));
`endif
    v    = v >>> sh;
    r.hi = (v > mx);
    r.lo = (v < mn);
    r.val = r.hi ? mx : (r.lo ? mn : v);
    r.t  = 0;
    return r;
  endfunction

  task automatic step(input logic iv, input logic signed [IN_W-1:0] d, input int sh,
                      input logic ordy, input logic clr, output logic acc);
    logic  ov_exp, xo;
    exp_t  e;
    @(negedge clk);
    in_valid = iv; in_dat = d; shift = SH_W'(sh); out_ready = ordy; clear_count = clr;
    #1;
    ov_exp = (q.size() > 0) && (q[0].t < cyc);
    chk("in_ready", in_ready, (q.size() < 2) || ordy);
    chk("in_ready_c2", in_ready2, (q.size() < 2) || ordy);
    chk("out_valid", out_valid, ov_exp);
    chk("out_valid_c2", out_valid2, ov_exp);
    if (ov_exp) begin
      chk("out", out_dat, q[0].val);
      chk("out_c2", out_dat2, q[0].val);
      chk("sat_hi", sat_hi, q[0].hi);
      chk("sat_lo", sat_lo, q[0].lo);
    end
    chk("sat_count", sat_count, cnt_a);
    chk("sat_count_c2", sat_count2, cnt_b);
    acc = iv && in_ready;
    xo  = ov_exp && ordy;
    @(posedge clk);
    cyc++;
    if (xo) begin
      e = q.pop_front();
      if (clr) begin
        cnt_a = 0; cnt_b = 0;
      end else if (e.hi || e.lo) begin
        if (cnt_a < (1 << CNT_W) - 1) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
    end else if (clr) begin
      cnt_a = 0; cnt_b = 0;
    end
    if (acc) begin
      e   = model(longint'(d), sh);
      e.t = cyc;
      q.push_back(e);
    end
  endtask

  task automatic send1(input longint d, input int sh);
    logic a;
    step(1'b1, IN_W'(d), sh, 1'b1, 1'b0, a);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) step(1'b0, '0, 0, 1'b1, 1'b0, a);
  endtask

  initial begin
    logic                   acc;
    logic                   pend;
    logic signed [IN_W-1:0] rd;
    int                     rsh;
    int                     sent;
    longint                 bases[4];
    bases[0] = 32767; bases[1] = 32768; bases[2] = -32768; bases[3] = -32769;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out_dat, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Boundaries at shift=0
    send1(32767, 0);
    send1(32768, 0);
    #1; chk("tp_max_out", out_dat, 32767); chk("tp_max_hi", sat_hi, 0);
    send1(-32768, 0);
    #1; chk("tp_over_out", out_dat, 32767); chk("tp_over_hi", sat_hi, 1);
    send1(-32769, 0);
    #1; chk("tp_min_out", out_dat, -32768); chk("tp_min_lo", sat_lo, 0);
    idle(1);
    #1; chk("tp_under_out", out_dat, -32768); chk("tp_under_lo", sat_lo, 1);
    idle(2);
    #1; chk("tp_count2", sat_count, 2);

    // shift=4, rounding-dependent
    send1(524280, 4);
    send1(-24, 4);
    #1;
`ifdef SATURATE_ROUND_EN
    chk("sh4_pos_out", out_dat, 32767); chk("sh4_pos_hi", sat_hi, 1);
`else
    chk("sh4_pos_out", out_dat, 32767); chk("sh4_pos_hi", sat_hi, 0);
`endif
    idle(1);
    #1;
`ifdef SATURATE_ROUND_EN
    chk("sh4_neg_out", out_dat, -1);
`else
    chk("sh4_neg_out", out_dat, -2);
`endif
    idle(2);

    // Backpressure: 4 back-to-back samples, 3 stalled cycles
    sent = 0;
    for (int k = 0; k < 10; k++) begin
      step(sent < 4, IN_W'(sent + 1), 0, k >= 3, 1'b0, acc);
      if (acc) sent++;
      if (k == 2) chk("bp_accepted_in_stall", sent, 2);
    end
    chk("bp_all_sent", sent, 4);
    idle(3);

    // Counter: clear, 3 clips, 5 clips (CNT_W=2 sticks), clear coinciding with clip
    step(1'b0, '0, 0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 3; k++) send1(40000, 0);
    idle(3);
    #1; chk("cnt_three", sat_count, 3); chk("cnt_three_c2", sat_count2, 3);
    for (int k = 0; k < 2; k++) send1(-40000, 0);
    idle(3);
    #1; chk("cnt_five", sat_count, 5); chk("cnt_sticky_c2", sat_count2, 3);
    send1(40000, 0);
    idle(1);
    step(1'b0, '0, 0, 1'b1, 1'b1, acc);
    #1; chk("cnt_clear_wins", sat_count, 0); chk("cnt_clear_wins_c2", sat_count2, 0);
    idle(1);

    // Randomized phase
    pend = 1'b0; rd = '0; rsh = 0;
    for (int k = 0; k < 600; k++) begin
      if (!pend) begin
        pend = ($urandom_range(3, 0) != 0);
        if ($urandom_range(2, 0) == 0) begin
          rsh = $urandom_range(IN_W-1, 0);
          rd  = IN_W'($urandom);
        end else begin
          rsh = $urandom_range(15, 0);
          rd  = IN_W'((bases[$urandom_range(3, 0)] <<< rsh) + longint'($urandom_range(6, 0)) - 3);
        end
      end
      step(pend, rd, rsh, $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0, acc);
      if (acc) pend = 1'b0;
    end
    idle(3);

    // Reset mid-stream with both stages full and a nonzero count
    send1(70000, 0);
    idle(2);
    step(1'b1, IN_W'(100), 0, 1'b0, 1'b0, acc);
    step(1'b1, IN_W'(-70000), 0, 1'b0, 1'b0, acc);
    step(1'b1, IN_W'(300), 0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out", out_dat, 0);
    chk("mid_rst_sat_hi", sat_hi, 0);
    chk("mid_rst_sat_lo", sat_lo, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    reset = 1'b0;
    send1(-5, 3);
    #1; chk("post_rst_no_stale", out_valid, 0);
    idle(1);
    #1; chk("post_rst_valid", out_valid, 1); chk("post_rst_out", out_dat, -1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
